// File: rtl/ysyx_25040101_mdu_pkg.sv
// ============================================================================
// Module : ysyx_25040101_mdu_pkg
// Brief  : Shared op encodings, FSM states and width for the RV32M MDU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25040101_mdu_pkg;

   localparam int XLEN = 32;

   // funct3 encodings of the M extension
   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_25040101_mdu_iter.sv
// ============================================================================
// Module : ysyx_25040101_mdu_iter
// Brief  : One combinational shift-add multiply or restoring divide step.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25040101_mdu_iter
   import ysyx_25040101_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] i_acc,
   input  logic [XLEN-1:0]   i_opnd,
   input  logic              i_is_div,
   output logic [2*XLEN-1:0] o_acc
);

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_rem_sh;
   logic [XLEN-1:0] w_sub;
   logic            w_ge;

   // Multiply: {hi, multiplier} register, add multiplicand into hi, shift right.
   assign w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + ({(XLEN+1){i_acc[0]}} & {1'b0, i_opnd});

   // Divide: {remainder, dividend} register, shift left, trial subtract.
   assign w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
   assign w_ge     = (w_rem_sh >= {1'b0, i_opnd});
   assign w_sub    = w_rem_sh[XLEN-1:0] - i_opnd;

   always_comb begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
      if (i_is_div) begin
         if (w_ge) begin
            o_acc = {w_sub, i_acc[XLEN-2:0], 1'b1};
         end else begin
            o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ysyx_25040101_mdu.sv
// ============================================================================
// Module : ysyx_25040101_mdu
// Brief  : Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25040101_mdu
   import ysyx_25040101_mdu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      mdu_op_i,
   input  logic [XLEN-1:0] srca_data_i,
   input  logic [XLEN-1:0] srcb_data_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_opnd;
   logic [XLEN-1:0]   r_result;
   logic [2*XLEN-1:0] r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_special;

   logic              w_accept;
   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_div_zero;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_special_res;
   logic              w_fix_cycle;
   logic [2*XLEN-1:0] w_acc_step;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fixed;

   assign ready_o  = rst_n & (r_state == S_IDLE);
   assign valid_o  = (r_state == S_DONE);
   assign result_o = r_result;
   assign w_accept = valid_i & ready_o & ~flush_i;

   assign w_a_signed = (mdu_op_i == MDU_MULH) | (mdu_op_i == MDU_MULHSU) |
                       (mdu_op_i == MDU_DIV)  | (mdu_op_i == MDU_REM);
   assign w_b_signed = (mdu_op_i == MDU_MULH) | (mdu_op_i == MDU_DIV) | (mdu_op_i == MDU_REM);
   assign w_sa       = w_a_signed & srca_data_i[XLEN-1];
   assign w_sb       = w_b_signed & srcb_data_i[XLEN-1];
   assign w_mag_a    = w_sa ? (~srca_data_i + 1'b1) : srca_data_i;
   assign w_mag_b    = w_sb ? (~srcb_data_i + 1'b1) : srcb_data_i;

   assign w_div_zero = mdu_op_i[2] & (srcb_data_i == '0);
   assign w_ovf      = ((mdu_op_i == MDU_DIV) | (mdu_op_i == MDU_REM)) &
                       (srca_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (srcb_data_i == '1);
   assign w_special  = w_div_zero | w_ovf;

   // op[1] separates rem/remu from div/divu within the divide group
   always_comb begin
      w_special_res = '1;
      if (w_div_zero) begin
         w_special_res = mdu_op_i[1] ? srca_data_i : '1;
      end else if (w_ovf) begin
         w_special_res = mdu_op_i[1] ? '0 : srca_data_i;
      end
   end

   assign w_fix_cycle = (r_cnt == CNT_W'(XLEN));

   ysyx_25040101_mdu_iter #(
      .XLEN (XLEN)
   ) u_iter (
      .i_acc    (r_acc),
      .i_opnd   (r_opnd),
      .i_is_div (r_op[2]),
      .o_acc    (w_acc_step)
   );

   assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
   assign w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
   assign w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_fixed = w_prod[2*XLEN-1:XLEN];
      case (r_op)
         MDU_MUL:            w_fixed = w_prod[XLEN-1:0];
         MDU_DIV, MDU_DIVU:  w_fixed = w_quo;
         MDU_REM, MDU_REMU:  w_fixed = w_rem;
         default:            w_fixed = w_prod[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
         S_BUSY:  if (r_special | w_fix_cycle) w_state_nxt = S_DONE;
         S_DONE:  if (ready_i) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush_i) begin
         w_state_nxt = S_IDLE;
      end
   end

   // Special results are latched at accept; BUSY then only spends one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op      <= '0;
         r_opnd    <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_special <= 1'b0;
         r_result  <= '0;
      end else if (w_accept) begin
         r_op      <= mdu_op_i;
         r_opnd    <= mdu_op_i[2] ? w_mag_b : w_mag_a;
         r_acc     <= {{XLEN{1'b0}}, (mdu_op_i[2] ? w_mag_a : w_mag_b)};
         r_cnt     <= '0;
         r_neg_q   <= w_sa ^ w_sb;
         r_neg_r   <= w_sa;
         r_special <= w_special;
         if (w_special) begin
            r_result <= w_special_res;
         end
      end else if ((r_state == S_BUSY) && !flush_i && !r_special) begin
         if (w_fix_cycle) begin
            r_result <= w_fixed;
         end else begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040101_mdu.sv
// ============================================================================
// Module : tb_ysyx_25040101_mdu
// Brief  : Self-checking bench for the RV32M MDU against an arithmetic model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25040101_mdu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [2:0]  mdu_op_i;
   logic [31:0] srca_data_i;
   logic [31:0] srcb_data_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;

   int total = 0;
   int bad   = 0;

   ysyx_25040101_mdu #(
      .XLEN  (32),
      .CNT_W (6)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .mdu_op_i    (mdu_op_i),
      .srca_data_i (srca_data_i),
      .srcb_data_i (srcb_data_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .result_o    (result_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      int sa;
      int sb;
      sa = a;
      sb = b;
      p  = '0;
      case (op)
         3'b000: begin p = {32'b0, a} * {32'b0, b};             return p[31:0];  end
         3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
         3'b011: begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // Entered and left 1 time unit after a rising edge with the unit idle.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input string tag);
      logic [31:0] exp;
      int          lat;
      exp = ref_mdu(op, a, b);
      check({tag, "/ready_before"}, {31'b0, ready_o}, 32'd1);
      ready_i     = !hold;
      valid_i     = 1'b1;
      mdu_op_i    = op;
      srca_data_i = a;
      srcb_data_i = b;
      @(posedge clk); #1;
      valid_i     = 1'b0;
      mdu_op_i    = 3'($urandom);
      srca_data_i = $urandom;
      srcb_data_i = $urandom;
      lat = 0;
      while (!valid_o && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "/latency"}, lat, ref_latency(op, a, b));
      check({tag, "/result"}, result_o, exp);
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            valid_i     = 1'b1;
            mdu_op_i    = 3'($urandom);
            srca_data_i = $urandom;
            srcb_data_i = 32'h0;
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, {31'b0, valid_o}, 32'd1);
            check({tag, "/hold_result"}, result_o, exp);
            check({tag, "/hold_ready"}, {31'b0, ready_o}, 32'd0);
         end
         valid_i = 1'b0;
         ready_i = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, "/valid_after"}, {31'b0, valid_o}, 32'd0);
      check({tag, "/ready_after"}, {31'b0, ready_o}, 32'd1);
   endtask

   initial begin
      int pulses;
      rst_n       = 1'b0;
      flush_i     = 1'b0;
      valid_i     = 1'b0;
      ready_i     = 1'b1;
      mdu_op_i    = 3'b000;
      srca_data_i = 32'h0;
      srcb_data_i = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      check("reset/ready", {31'b0, ready_o}, 32'd0);
      check("reset/valid", {31'b0, valid_o}, 32'd0);
      check("reset/result", result_o, 32'd0);
      rst_n = 1'b1;
      #1;
      check("reset/ready_release", {31'b0, ready_o}, 32'd1);
      @(posedge clk); #1;

      do_op(3'b000, 32'd7, 32'd6, 1'b0, "mul_7x6");
      do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulh_m1");
      do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu_max");
      do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0, "mulhsu_m1x2");
      do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
      do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
      do_op(3'b101, 32'd100, 32'd7, 1'b0, "divu_100_7");
      do_op(3'b111, 32'd100, 32'd7, 1'b0, "remu_100_7");
      do_op(3'b100, 32'd5, 32'd0, 1'b0, "div_by0");
      do_op(3'b110, 32'd5, 32'd0, 1'b0, "rem_by0");
      do_op(3'b101, 32'd9, 32'd0, 1'b0, "divu_by0");
      do_op(3'b111, 32'd9, 32'd0, 1'b0, "remu_by0");
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
      do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
      do_op(3'b000, 32'h1234_5678, 32'h0, 1'b0, "mul_zero");
      do_op(3'b100, 32'hFFFF_FF9C, 32'd7, 1'b1, "div_backpressure");

      // flush in IDLE must suppress acceptance even with a one-cycle special op
      valid_i     = 1'b1;
      flush_i     = 1'b1;
      mdu_op_i    = 3'b100;
      srca_data_i = 32'd3;
      srcb_data_i = 32'd0;
      @(posedge clk); #1;
      valid_i = 1'b0;
      flush_i = 1'b0;
      @(posedge clk); #1;
      check("flush_idle/valid", {31'b0, valid_o}, 32'd0);
      check("flush_idle/ready", {31'b0, ready_o}, 32'd1);

      // flush at BUSY cycle 10
      valid_i     = 1'b1;
      mdu_op_i    = 3'b000;
      srca_data_i = 32'd123;
      srcb_data_i = 32'd456;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("flush_busy/ready", {31'b0, ready_o}, 32'd1);
      check("flush_busy/valid", {31'b0, valid_o}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valid_o) pulses++;
      end
      check("flush_busy/no_pulse", pulses, 32'd0);
      do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0, "after_flush");

      // reset mid-BUSY
      valid_i     = 1'b1;
      mdu_op_i    = 3'b101;
      srca_data_i = 32'd1000;
      srcb_data_i = 32'd3;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid/valid", {31'b0, valid_o}, 32'd0);
      check("rst_mid/result", result_o, 32'd0);
      check("rst_mid/ready", {31'b0, ready_o}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_mid/ready_release", {31'b0, ready_o}, 32'd1);
      @(posedge clk); #1;
      do_op(3'b111, 32'd1000, 32'd3, 1'b0, "after_reset");

      for (int n = 0; n < 40; n++) begin
         do_op(3'($urandom), pick_operand(), pick_operand(), 1'b0, $sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ysyx_25040101_mdu.md
Name: ysyx_25040101_mdu

Overview:
- Iterative RV32M multiply/divide unit: the consumer end of the ALU operand-select path.
- Takes srca/srcb operands (srcb = rs2 data from the srcb mux) plus funct3 op, runs a multi-cycle shift-add multiply or restoring divide, and returns one 32-bit result to writeback.
- Valid/ready handshake on both sides, so the core stalls while busy.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  abort in-flight op (pipeline redirect)
- valid_i  in  1  operands and op valid
- ready_o  out  1  unit can accept (state IDLE)
- mdu_op_i  in  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- srca_data_i  in  32  rs1 operand
- srcb_data_i  in  32  rs2 operand from srcb mux
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  32  result, stable while valid_o=1

Behaviour:
- Reset: state=IDLE, ready_o=0 during reset cycle then 1, valid_o=0, result_o=0, counter=0, datapath regs=0.
- States:
  - IDLE: ready_o=1. valid_i&ready_o accepts: latch op, magnitudes, sign flags.
    - Divisor==0 or signed overflow → DONE next cycle.
    - Otherwise → BUSY, counter=0.
  - BUSY: one iteration per cycle.
    - Multiply: 64-bit accumulator adds shifted multiplicand when the multiplier LSB is 1.
    - Divide: restoring shift/subtract producing one quotient bit.
    - After iteration 31 (counter==31) → DONE.
    - Final sign correction (negate quotient/remainder/product) applied on the DONE transition.
  - DONE: valid_o=1, result_o held. valid_o&ready_i → IDLE. ready_i low → hold indefinitely, result unchanged.
- Latency: handshake at edge T; normal op gives valid_o=1 from edge T+33; special case from edge T+1.
- Signedness:
  - mulh: both operands signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - mulhu/divu/remu: both unsigned.
  - Computed on magnitudes with a sign fix-up; 64-bit product.
  - mul returns low 32 bits; mulh/mulhsu/mulhu return high 32 bits.
- Division sign rules:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero: div/divu → 0xFFFFFFFF; rem/remu → dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): div → 0x80000000, rem → 0.
  - Multiply by zero is not special-cased and takes the full 32 cycles.
- flush_i:
  - In BUSY or DONE → IDLE next cycle, valid_o=0, result discarded.
  - In IDLE it suppresses acceptance that cycle, even if valid_i=1.
  - flush_i has priority over every transition.
- rst_n low mid-operation: returns to reset values next edge regardless of state.
- Inputs are ignored outside the IDLE handshake cycle; operands may change freely while BUSY.
- Back-to-back ops: DONE→IDLE costs one cycle, so the next accept occurs at the earliest one cycle after the result handshake.

Decomposition:
- Shared package contents:
  - mdu_op encoding localparams (MDU_MUL..MDU_REMU, matching funct3)
  - state encoding localparams (S_IDLE, S_BUSY, S_DONE)
  - XLEN
- Top module holds the FSM, handshake, counter and sign fix-up.
- One natural sub-module, ysyx_25040101_mdu_iter: combinational single-iteration step, taking accumulator/partial remainder plus operand and returning the next value, with a mul/div select.

Test Plan:
- mul 7×6: srca=7, srcb=6, op=000 → valid_o at T+33, result_o=42; ready_i=1 returns to IDLE, ready_o=1 next cycle.
- Signed high product: mulh 0xFFFFFFFF×0xFFFFFFFF → 0x00000000; mulhu same operands → 0xFFFFFFFE; mulhsu 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Signed division:
  - div −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD.
  - rem same operands → 0xFFFFFFFF.
  - divu 100/7 → 14.
  - remu 100/7 → 2.
- Special cases, each with valid_o at T+1:
  - div 5/0 → 0xFFFFFFFF.
  - rem 5/0 → 5.
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
  - rem same operands → 0.
- Backpressure: hold ready_i=0 for 10 cycles in DONE → valid_o=1 and result_o constant, ready_o=0, new valid_i ignored; raise ready_i → IDLE.
- Abort/reset:
  - flush_i at BUSY cycle 10 → IDLE next cycle, no valid_o pulse, next op's result correct.
  - rst_n=0 for one cycle mid-BUSY → all outputs at reset values next edge.
